lsu_byte_master: RTL
====================

// Module: lsu_byte_master
// PURPOSE
//   Initiator-side load/store sequencer between the core datapath and a byte-wide data memory port.
//   Accepts one word (LW/SW) or byte (LBU/SB) request at a time over a valid/ready handshake.
//   Splits each request into little-endian byte beats on the memory port and reassembles load data.
//   Returns the result as a single-cycle response pulse. Sits between the execute stage and data memory.
// PARAMETERS
//   DATA_WIDTH  32  core data width; fixed at 4 bytes per word access
//   ADDR_WIDTH  32  byte-address width
// PORTS
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   1           core request valid
//   req_ready  out  1           block can accept a request
//   req_we     in   1           1 = store, 0 = load
//   req_byte   in   1           1 = byte op (SB/LBU), 0 = word op (SW/LW)
//   req_addr   in   ADDR_WIDTH  byte base address; no alignment required
//   req_wdata  in   DATA_WIDTH  store data; byte op uses [7:0] only
//   rsp_valid  out  1           one-cycle completion pulse
//   rsp_rdata  out  DATA_WIDTH  load result; 0 for stores
//   mem_en     out  1           memory beat request
//   mem_we     out  1           beat is a write
//   mem_addr   out  ADDR_WIDTH  beat byte address
//   mem_wdata  out  8           beat write byte
//   mem_rdata  in   8           read byte; valid in the same cycle as mem_ack
//   mem_ack    in   1           beat completes at the rising edge where mem_en && mem_ack
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, beat index 0; all outputs 0 except req_ready=1.
//   FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE
//     - req_ready=1.
//     - On req_valid && req_ready: latch we, byte, addr, wdata; beat count N = byte ? 1 : 4; index=0; go to ACCESS.
//   ACCESS
//     - req_ready=0; mem_en=1; mem_we=latched we.
//     - mem_addr = base + index, modulo 2^ADDR_WIDTH (wraps 0xFFFF_FFFF -> 0x0000_0000).
//     - mem_wdata = wdata[8*index+7 : 8*index].
//     - mem_en, mem_addr, mem_we and mem_wdata hold stable until ack.
//     - On ack, loads capture mem_rdata into byte lane [index] of the assembly register; index++.
//     - On ack of beat N-1: go to RESP.
//   RESP
//     - rsp_valid=1 for exactly one cycle; mem_en=0; then IDLE. No response backpressure.
//     - rsp_rdata: loads = assembled little-endian word; LBU zero-extends byte 0 to 32 bits; stores = 0.
//     - rsp_rdata holds its value until the next RESP.
//   Latency with mem_ack tied high (accept at edge 0):
//     - Beats occupy cycles 1..N; rsp_valid is asserted in cycle N+1.
//     - Word ops: 6 cycles accept-to-accept; byte ops: 3 cycles.
//   Boundary conditions
//     - mem_ack while mem_en=0: ignored.
//     - mem_ack held low: stall in ACCESS indefinitely, outputs stable.
//     - req_valid outside IDLE: ignored; not latched.
//     - Core inputs changing after acceptance: no effect.
//     - rst_n asserted mid-operation: the request is abandoned; no rsp_valid; partial stores are not rolled back.
//   The assembly register clears on accept, so stale upper bytes never leak into an LBU result.
// TESTING
//   1. Word load, addr 0x10000, memory bytes 11 22 33 44, ack=1
//      -> beats at 0x10000..0x10003; rsp_rdata=0x44332211 in cycle 5.
//   2. Byte load, addr 0x10003, byte 0xF0
//      -> single beat; rsp_rdata=0x000000F0; no sign extension.
//   3. Word store 0xDEADBEEF to 0x20
//      -> mem_wdata EF, BE, AD, DE at 0x20..0x23 with mem_we=1; rsp_rdata=0.
//   4. Byte store 0x123456AB to 0x7
//      -> one beat, mem_wdata=0xAB, addr 0x7.
//   5. Word load at 0xFFFFFFFE with random ack gaps
//      -> addrs FFFFFFFE, FFFFFFFF, 00000000, 00000001; outputs stable while stalled; correct data.
//   6. rst_n low during beat 2 of SW, with req_valid held high in ACCESS
//      -> immediate IDLE, req_ready=1, no rsp_valid, held request not double-accepted.

Source files
------------

// File: rtl/lsu_byte_master.sv
// Load/store sequencer: turns one LW/SW/LBU/SB request into little-endian byte beats
// on a byte-wide memory port and reassembles load data into a one-cycle response.
module lsu_byte_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic                  byt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req_q;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] asm_q, asm_nxt, rsp_q;
  logic                  accept, beat_done, last_beat;

  assign accept    = (state == IDLE) && req_valid;
  assign beat_done = (state == ACCESS) && mem_ack;
  assign last_beat = req_q.byt || (idx == IW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = req_q.we;
        mem_addr  = req_q.addr + ADDR_WIDTH'(idx);
        mem_wdata = req_q.wdata[8*idx +: 8];
        if (mem_ack && last_beat) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte lane the current beat lands in, merged over the partial word.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[8*idx +: 8] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      idx   <= '0;
      asm_q <= '0;
      rsp_q <= '0;
    end else if (accept) begin
      req_q <= '{we: req_we, byt: req_byte, addr: req_addr, wdata: req_wdata};
      idx   <= '0;
      asm_q <= '0;
    end else if (beat_done) begin
      idx <= idx + 1'b1;
      if (!req_q.we) asm_q <= asm_nxt;
      // Result is registered on the final ack so it is ready in RESP and held afterwards.
      if (last_beat) begin
        if (req_q.we)       rsp_q <= '0;
        else if (req_q.byt) rsp_q <= DATA_WIDTH'(asm_nxt[7:0]);
        else                rsp_q <= asm_nxt;
      end
    end
  end

  assign rsp_rdata = rsp_q;

endmodule
